// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the ROM address,
// registers each fetched word for decode and freezes on a halt word.
module instr_fetch_unit #(
  parameter int                    PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
  parameter logic [31:0]           HALT_WORD = 32'hD4400000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                resume,
  input  logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] program_counter,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  typedef enum logic {
    FETCH,
    HALTED
  } state_t;

  state_t state;

  logic is_halt;
  assign is_halt = (instruction == HALT_WORD);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= FETCH;
      program_counter <= RESET_PC;
      instr_out       <= '0;
      instr_pc        <= '0;
      instr_valid     <= 1'b0;
      halted          <= 1'b0;
      fetch_count     <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          priority case (1'b1)
            branch_taken: begin
              program_counter <= branch_target;
              instr_valid     <= 1'b0;
            end
            stall: begin
              instr_valid <= instr_valid;
            end
            default: begin
              instr_out   <= instruction;
              instr_pc    <= program_counter;
              instr_valid <= 1'b1;
              if (fetch_count != 32'hFFFF_FFFF)
                fetch_count <= fetch_count + 32'd1;
              // The halt word is delivered once; the PC parks on it.
              if (is_halt) begin
                state  <= HALTED;
                halted <= 1'b1;
              end else begin
                program_counter <= program_counter + 1'b1;
              end
            end
          endcase
        end
        HALTED: begin
          instr_valid <= 1'b0;
          if (resume) begin
            program_counter <= program_counter + 1'b1;
            state           <= FETCH;
            halted          <= 1'b0;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
